dlx_lsu: RTL and testbench

- Parametrised load/store unit between the EX/MEM pipeline boundary and the data RAM port of the DLX core.
- Adds features the current data path lacks:
  - byte, half, word and (64-bit builds) doubleword accesses, with sign or zero extension;
  - a d_data_valid handshake with wait states;
  - a pipeline stall output;
  - misalignment and timeout error reporting.
- One request in flight at a time; big-endian byte ordering, as in DLX.

---
 rtl/dlx_lsu_pkg.sv | 25 ++
 rtl/dlx_lane_align.sv | 45 ++++
 rtl/dlx_lsu.sv | 135 +++++++++++++
 tb/tb_dlx_lsu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_lsu_pkg.sv
// Shared types and lane helpers for the DLX load/store unit.
package dlx_lsu_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
  typedef enum logic {IDLE, WAIT} state_t;

  function automatic logic [3:0] size_bytes(size_t size);
    return 4'd1 << size;
  endfunction

  // Byte-enable mask in 64-bit orientation: bit 7 is the lowest address.
  function automatic logic [7:0] lane_mask(size_t size, logic [2:0] off);
    return (8'hFF << (4'd8 - size_bytes(size))) >> off;
  endfunction

  function automatic logic misaligned(size_t size, logic [2:0] lo, logic wide);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      SZ_W:    return |lo[1:0];
      default: return !wide || (|lo);
    endcase
  endfunction

endpackage

// File: rtl/dlx_lane_align.sv
// Store-data lane replication and load-data extraction/extension (big-endian lanes).
module dlx_lane_align
  import dlx_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        st_size,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] st_rep,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [2:0]        ld_off,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [DATA_W-1:0] ld_data
);

  int                nbits;
  int                shamt;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] keep;
  logic [DATA_W-1:0] top;

  always_comb begin
    // NOTE: assign a default before the case so no path leaves st_rep unassigned (no latch).
    st_rep = st_data;
    case (size_t'(st_size))
      SZ_B:    st_rep = {(DATA_W/8){st_data[7:0]}};
      SZ_H:    st_rep = {(DATA_W/16){st_data[15:0]}};
      SZ_W:    st_rep = {(DATA_W/32){st_data[31:0]}};
      default: ;
    endcase
  end

  // Shift the addressed lanes down to bit 0, keep them, then fill above with the sign.
  always_comb begin
    nbits = 8 * int'(size_bytes(size_t'(ld_size)));
    if (nbits > DATA_W) nbits = DATA_W;
    shamt   = DATA_W - 8 * int'(ld_off) - nbits;
    lane    = ld_raw >> shamt;
    keep    = {DATA_W{1'b1}} >> (DATA_W - nbits);
    top     = keep & ~(keep >> 1);
    ld_data = (lane & keep) | ({DATA_W{ld_signed && (|(lane & top))}} & ~keep);
  end

endmodule

// File: rtl/dlx_lsu.sv
// DLX load/store unit: one access in flight, wait-state handshake, misalign/timeout errors.
module dlx_lsu
  import dlx_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [4:0]          req_rd,
  output logic                req_ready,
  output logic                stall,
  output logic                d_req,
  output logic [ADDR_W-1:0]   d_address,
  output logic [DATA_W-1:0]   d_data_write,
  output logic                d_write_enable,
  output logic [DATA_W/8-1:0] d_byte_en,
  input  logic [DATA_W-1:0]   d_data_read,
  input  logic                d_data_valid,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [DATA_W-1:0]   wb_data,
  output logic                misaligned_err,
  output logic                timeout_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_write;
  logic              lat_signed;
  logic [1:0]        lat_size;
  logic [2:0]        lat_off;
  logic [4:0]        lat_rd;
  logic [NB-1:0]     lat_be;

  logic [2:0]        req_off;
  logic [7:0]        req_mask;
  logic              req_mis;
  logic [DATA_W-1:0] st_rep;
  logic [DATA_W-1:0] ld_data;

  assign req_off  = 3'(req_addr[OFF_W-1:0]);
  assign req_mask = lane_mask(size_t'(req_size), req_off);
  assign req_mis  = misaligned(size_t'(req_size), req_addr[2:0], DATA_W == 64);

  assign req_ready      = (state == IDLE);
  assign stall          = !req_ready;
  assign d_req          = (state == WAIT);
  assign d_write_enable = d_req && lat_write;
  assign d_byte_en      = d_req ? lat_be : '0;

  dlx_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_size   (req_size),
    .st_data   (req_wdata),
    .st_rep    (st_rep),
    .ld_size   (lat_size),
    .ld_signed (lat_signed),
    .ld_off    (lat_off),
    .ld_raw    (d_data_read),
    .ld_data   (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_write      <= 1'b0;
      lat_signed     <= 1'b0;
      lat_size       <= 2'b00;
      lat_off        <= 3'b000;
      lat_rd         <= 5'd0;
      lat_be         <= '0;
      d_address      <= '0;
      d_data_write   <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= 5'd0;
      wb_data        <= '0;
      misaligned_err <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      wb_valid       <= 1'b0;
      misaligned_err <= 1'b0;
      timeout_err    <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            if (req_mis) begin
              misaligned_err <= 1'b1;
            end else begin
              state        <= WAIT;
              lat_write    <= req_write;
              lat_signed   <= req_signed;
              lat_size     <= req_size;
              lat_off      <= req_off;
              lat_rd       <= req_rd;
              lat_be       <= NB'(req_mask >> (8 - NB));
              d_address    <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
              d_data_write <= st_rep;
            end
          end
        end
        default: begin
          // A completing response beats a timeout in the same cycle.
          if (d_data_valid) begin
            state <= IDLE;
            if (!lat_write) begin
              wb_valid <= 1'b1;
              wb_rd    <= lat_rd;
              wb_data  <= ld_data;
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_lsu.sv
// Directed bench for dlx_lsu: 32-bit instance (TIMEOUT=4) and 64-bit instance.
module tb_dlx_lsu;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        n_req_valid, n_req_write, n_req_signed, n_d_data_valid;
  logic [1:0]  n_req_size;
  logic [31:0] n_req_addr, n_req_wdata, n_d_data_read;
  logic [4:0]  n_req_rd;
  logic        n_req_ready, n_stall, n_d_req, n_d_we, n_wb_valid, n_mis, n_tmo;
  logic [31:0] n_d_address, n_d_data_write, n_wb_data;
  logic [3:0]  n_d_byte_en;
  logic [4:0]  n_wb_rd;

  // 64-bit instance signals
  logic        w_req_valid, w_req_write, w_req_signed, w_d_data_valid;
  logic [1:0]  w_req_size;
  logic [31:0] w_req_addr;
  logic [63:0] w_req_wdata, w_d_data_read;
  logic [4:0]  w_req_rd;
  logic        w_req_ready, w_stall, w_d_req, w_d_we, w_wb_valid, w_mis, w_tmo;
  logic [31:0] w_d_address;
  logic [63:0] w_d_data_write, w_wb_data;
  logic [7:0]  w_d_byte_en;
  logic [4:0]  w_wb_rd;

  dlx_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_n (
    .clk(clk), .reset_n(reset_n),
    .req_valid(n_req_valid), .req_write(n_req_write), .req_size(n_req_size),
    .req_signed(n_req_signed), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
    .req_rd(n_req_rd), .req_ready(n_req_ready), .stall(n_stall), .d_req(n_d_req),
    .d_address(n_d_address), .d_data_write(n_d_data_write), .d_write_enable(n_d_we),
    .d_byte_en(n_d_byte_en), .d_data_read(n_d_data_read), .d_data_valid(n_d_data_valid),
    .wb_valid(n_wb_valid), .wb_rd(n_wb_rd), .wb_data(n_wb_data),
    .misaligned_err(n_mis), .timeout_err(n_tmo)
  );

  dlx_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) u_w (
    .clk(clk), .reset_n(reset_n),
    .req_valid(w_req_valid), .req_write(w_req_write), .req_size(w_req_size),
    .req_signed(w_req_signed), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
    .req_rd(w_req_rd), .req_ready(w_req_ready), .stall(w_stall), .d_req(w_d_req),
    .d_address(w_d_address), .d_data_write(w_d_data_write), .d_write_enable(w_d_we),
    .d_byte_en(w_d_byte_en), .d_data_read(w_d_data_read), .d_data_valid(w_d_data_valid),
    .wb_valid(w_wb_valid), .wb_rd(w_wb_rd), .wb_data(w_wb_data),
    .misaligned_err(w_mis), .timeout_err(w_tmo)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] wb;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v, input int idx);
    int stalls;
    stalls = 0;
    @(negedge clk);
    check($sformatf("v%0d_ready", idx), 64'(n_req_ready), 64'd1);
    n_req_valid  = 1'b1;
    n_req_write  = v.wr;
    n_req_size   = v.size;
    n_req_signed = v.sgn;
    n_req_addr   = v.addr;
    n_req_wdata  = v.wdata;
    n_req_rd     = 5'(idx + 1);
    @(negedge clk);
    n_req_valid = 1'b0;
    if (v.mis) begin
      check($sformatf("v%0d_mis_err", idx), 64'(n_mis), 64'd1);
      check($sformatf("v%0d_mis_dreq", idx), 64'(n_d_req), 64'd0);
      check($sformatf("v%0d_mis_ready", idx), 64'(n_req_ready), 64'd1);
      @(negedge clk);
      check($sformatf("v%0d_mis_once", idx), 64'(n_mis), 64'd0);
      check($sformatf("v%0d_mis_dreq2", idx), 64'(n_d_req), 64'd0);
    end else begin
      check($sformatf("v%0d_mis_none", idx), 64'(n_mis), 64'd0);
      check($sformatf("v%0d_be", idx), 64'(n_d_byte_en), 64'(v.be));
      check($sformatf("v%0d_daddr", idx), 64'(n_d_address), 64'(v.daddr));
      check($sformatf("v%0d_we", idx), 64'(n_d_we), 64'(v.wr));
      if (v.wr) check($sformatf("v%0d_dwdata", idx), 64'(n_d_data_write), 64'(v.dwdata));
      for (int c = 1; c <= v.waits; c++) begin
        if (n_stall) stalls++;
        n_d_data_valid = (c == v.waits);
        n_d_data_read  = v.rdata;
        @(negedge clk);
      end
      n_d_data_valid = 1'b0;
      check($sformatf("v%0d_stall_cycles", idx), 64'(stalls), 64'(v.waits));
      check($sformatf("v%0d_stall_end", idx), 64'(n_stall), 64'd0);
      check($sformatf("v%0d_wb_valid", idx), 64'(n_wb_valid), 64'(!v.wr));
      check($sformatf("v%0d_tmo", idx), 64'(n_tmo), 64'd0);
      if (!v.wr) begin
        check($sformatf("v%0d_wb_data", idx), 64'(n_wb_data), 64'(v.wb));
        check($sformatf("v%0d_wb_rd", idx), 64'(n_wb_rd), 64'(idx + 1));
      end
    end
  endtask

  task automatic issue32(input logic [31:0] addr, input logic [4:0] rd);
    n_req_valid  = 1'b1;
    n_req_write  = 1'b0;
    n_req_size   = 2'b10;
    n_req_signed = 1'b0;
    n_req_addr   = addr;
    n_req_rd     = rd;
  endtask

  task automatic run64(input string name, input logic wr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rdata, input logic [7:0] be,
                       input logic [31:0] daddr, input logic [63:0] exp);
    @(negedge clk);
    w_req_valid  = 1'b1;
    w_req_write  = wr;
    w_req_size   = size;
    w_req_signed = sgn;
    w_req_addr   = addr;
    w_req_wdata  = wdata;
    w_req_rd     = 5'd21;
    @(negedge clk);
    w_req_valid = 1'b0;
    check({name, "_dreq"}, 64'(w_d_req), 64'd1);
    check({name, "_be"}, 64'(w_d_byte_en), 64'(be));
    check({name, "_daddr"}, 64'(w_d_address), 64'(daddr));
    if (wr) check({name, "_dwdata"}, w_d_data_write, exp);
    w_d_data_valid = 1'b1;
    w_d_data_read  = rdata;
    @(negedge clk);
    w_d_data_valid = 1'b0;
    check({name, "_wb_valid"}, 64'(w_wb_valid), 64'(!wr));
    if (!wr) check({name, "_wb_data"}, w_wb_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_req_valid = 0; n_req_write = 0; n_req_signed = 0; n_d_data_valid = 0;
    n_req_size = 0; n_req_addr = 0; n_req_wdata = 0; n_d_data_read = 0; n_req_rd = 0;
    w_req_valid = 0; w_req_write = 0; w_req_signed = 0; w_d_data_valid = 0;
    w_req_size = 0; w_req_addr = 0; w_req_wdata = 0; w_d_data_read = 0; w_req_rd = 0;

    //           wr    size   sgn   addr        wdata         rdata         w  mis   be      daddr         dwdata        wb
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 3, 1'b0, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        32'h112233F0, 1, 1'b0, 4'b0001, 32'h100, 32'h0,        32'hFFFFFFF0};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h112233F0, 1, 1'b0, 4'b0001, 32'h100, 32'h0,        32'h000000F0};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 32'h0,        2, 1'b0, 4'b0011, 32'h100, 32'hABCDABCD, 32'h0};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h101, 32'h0,        32'h0,        1, 1'b1, 4'b0000, 32'h0,   32'h0,        32'h0};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h100, 32'h0,        32'h80011234, 2, 1'b0, 4'b1100, 32'h100, 32'h0,        32'hFFFF8001};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A, 32'h0,        1, 1'b0, 4'b0100, 32'h100, 32'h5A5A5A5A, 32'h0};
    vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h103, 32'h0,        32'h0,        1, 1'b1, 4'b0000, 32'h0,   32'h0,        32'h0};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 32'h101, 32'h0,        32'h117F3344, 4, 1'b0, 4'b0100, 32'h100, 32'h0,        32'h0000007F};
    vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h108, 32'h0,        32'h0,        1, 1'b1, 4'b0000, 32'h0,   32'h0,        32'h0};
    vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h104, 32'h12345678, 32'h0,        1, 1'b0, 4'b1111, 32'h104, 32'h12345678, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(n_req_ready), 64'd1);
    check("rst_stall", 64'(n_stall), 64'd0);
    check("rst_dreq", 64'(n_d_req), 64'd0);
    check("rst_be", 64'(n_d_byte_en), 64'd0);
    check("rst_wb_valid", 64'(n_wb_valid), 64'd0);
    check("rst_wb_data", 64'(n_wb_data), 64'd0);
    check("rst_daddr", 64'(n_d_address), 64'd0);
    check("rst_errs", 64'({n_mis, n_tmo}), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Timeout: no response for TIMEOUT=4 WAIT cycles
    @(negedge clk);
    issue32(32'h200, 5'd7);
    @(negedge clk);
    n_req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("to_stall_c%0d", c), 64'(n_stall), 64'd1);
      check($sformatf("to_err_early_c%0d", c), 64'(n_tmo), 64'd0);
      @(negedge clk);
    end
    check("to_err", 64'(n_tmo), 64'd1);
    check("to_ready", 64'(n_req_ready), 64'd1);
    check("to_wb_valid", 64'(n_wb_valid), 64'd0);
    check("to_dreq", 64'(n_d_req), 64'd0);
    @(negedge clk);
    check("to_err_once", 64'(n_tmo), 64'd0);

    // Response arriving in the timeout cycle wins, then a back-to-back request
    issue32(32'h200, 5'd8);
    @(negedge clk);
    n_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_d_data_valid = 1'b1;
    n_d_data_read  = 32'hCAFEF00D;
    @(negedge clk);
    n_d_data_valid = 1'b0;
    check("race_wb_valid", 64'(n_wb_valid), 64'd1);
    check("race_tmo", 64'(n_tmo), 64'd0);
    check("race_wb_data", 64'(n_wb_data), 64'hCAFEF00D);
    check("b2b_ready", 64'(n_req_ready), 64'd1);
    issue32(32'h300, 5'd9);
    @(negedge clk);
    n_req_valid = 1'b0;
    check("b2b_dreq", 64'(n_d_req), 64'd1);
    check("b2b_daddr", 64'(n_d_address), 64'h300);
    n_d_data_valid = 1'b1;
    n_d_data_read  = 32'h0BADF00D;
    @(negedge clk);
    n_d_data_valid = 1'b0;
    check("b2b_wb_valid", 64'(n_wb_valid), 64'd1);
    check("b2b_wb_data", 64'(n_wb_data), 64'h0BADF00D);
    check("b2b_wb_rd", 64'(n_wb_rd), 64'd9);

    // Reset mid-WAIT followed by a late response
    issue32(32'h400, 5'd3);
    @(negedge clk);
    n_req_valid = 1'b0;
    check("rmw_dreq_before", 64'(n_d_req), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n        = 1'b1;
    n_d_data_valid = 1'b1;
    n_d_data_read  = 32'h55555555;
    check("rmw_dreq", 64'(n_d_req), 64'd0);
    check("rmw_be", 64'(n_d_byte_en), 64'd0);
    check("rmw_daddr", 64'(n_d_address), 64'd0);
    check("rmw_wb_data", 64'(n_wb_data), 64'd0);
    check("rmw_wb_rd", 64'(n_wb_rd), 64'd0);
    check("rmw_ready", 64'(n_req_ready), 64'd1);
    @(negedge clk);
    n_d_data_valid = 1'b0;
    check("rmw_late_wb_valid", 64'(n_wb_valid), 64'd0);
    check("rmw_late_dreq", 64'(n_d_req), 64'd0);
    check("rmw_late_wb_data", 64'(n_wb_data), 64'd0);

    // 64-bit build
    run64("d64_dword", 1'b0, 2'b11, 1'b0, 32'h08, 64'h0, 64'h0123456789ABCDEF,
          8'hFF, 32'h08, 64'h0123456789ABCDEF);
    run64("d64_sbyte", 1'b0, 2'b00, 1'b1, 32'h0D, 64'h0, 64'h0123456789ABCDEF,
          8'b0000_0100, 32'h08, 64'hFFFFFFFFFFFFFFAB);
    run64("d64_wstore", 1'b1, 2'b10, 1'b0, 32'h0C, 64'h00000000AABBCCDD, 64'h0,
          8'b0000_1111, 32'h08, 64'hAABBCCDDAABBCCDD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
